// File: rtl/iseq.sv
// iseq: instruction fetch / microcode step sequencer for the 8-bit core.
// It fetches the opcode and up to three operand bytes over a req/ack read port,
// then walks the microcode step index until the microcode signals end-of-instruction.
// Memory timeouts and step overruns lock the sequencer in a sticky FAULT state.
module iseq #(
   parameter int ADDR_W      = 16,
   parameter int MAX_STEP    = 7,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   input  logic [1:0]        len,
   input  logic              ins_end,
   input  logic              stall,
   input  logic              halt,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        insn,
   output logic [7:0]        d1,
   output logic [7:0]        d2,
   output logic [7:0]        d3,
   output logic [2:0]        is,
   output logic              exec,
   output logic              halted,
   output logic              fault
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      FETCH_OP,
      FETCH_D,
      DECODE,
      EXEC,
      HALT,
      FAULT
   } state_t;

   state_t            state_reg, state_next;
   logic              req_reg, req_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic [1:0]        len_reg, len_next;
   logic [1:0]        cnt_reg, cnt_next;
   logic [TW-1:0]     tmo_reg, tmo_next;
   logic [TW-1:0]     tmo_inc;
   logic              tmo_hit;
   logic [7:0]        insn_reg, insn_next;
   logic [2:0]        is_reg, is_next;
   logic              d_clr;
   logic              d_wr;
   logic [2:0][7:0]   d_bus;

   assign tmo_inc = tmo_reg + TW'(1);
   assign tmo_hit = (tmo_inc == TW'(MEM_TIMEOUT));

   // Next-state and datapath decisions; FETCH_OP with req low is its entry cycle.
   always_comb begin
      state_next = state_reg;
      req_next   = req_reg;
      addr_next  = addr_reg;
      base_next  = base_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      tmo_next   = tmo_reg;
      insn_next  = insn_reg;
      is_next    = is_reg;
      d_clr      = 1'b0;
      d_wr       = 1'b0;
      case (state_reg)
         FETCH_OP: begin
            if (!req_reg) begin
               if (halt) begin
                  state_next = HALT;
               end else begin
                  base_next = pc_addr;
                  addr_next = pc_addr;
                  req_next  = 1'b1;
                  tmo_next  = '0;
               end
            end else if (mem_ack) begin
               insn_next  = mem_rdata;
               req_next   = 1'b0;
               tmo_next   = '0;
               state_next = DECODE;
            end else begin
               tmo_next = tmo_inc;
               if (tmo_hit) begin
                  req_next   = 1'b0;
                  state_next = FAULT;
               end
            end
         end
         DECODE: begin
            len_next = len;
            if (len == 2'd0) begin
               is_next    = '0;
               state_next = EXEC;
            end else begin
               d_clr      = 1'b1;
               cnt_next   = 2'd1;
               addr_next  = base_reg + ADDR_W'(1);
               req_next   = 1'b1;
               tmo_next   = '0;
               state_next = FETCH_D;
            end
         end
         FETCH_D: begin
            if (mem_ack) begin
               d_wr     = 1'b1;
               tmo_next = '0;
               if (cnt_reg == len_reg) begin
                  req_next   = 1'b0;
                  is_next    = '0;
                  state_next = EXEC;
               end else begin
                  // Request stays up; only the address moves to the next operand byte.
                  cnt_next  = cnt_reg + 2'd1;
                  addr_next = base_reg + ADDR_W'(cnt_reg) + ADDR_W'(1);
               end
            end else begin
               tmo_next = tmo_inc;
               if (tmo_hit) begin
                  req_next   = 1'b0;
                  state_next = FAULT;
               end
            end
         end
         EXEC: begin
            if (stall) begin
               is_next = is_reg;
            end else if (ins_end) begin
               is_next    = '0;
               state_next = FETCH_OP;
            end else if (is_reg == 3'(MAX_STEP)) begin
               is_next    = '0;
               state_next = FAULT;
            end else begin
               is_next = is_reg + 3'd1;
            end
         end
         HALT: begin
            // Leaving HALT doubles as the fetch entry cycle, so the request starts at once.
            if (!halt) begin
               base_next  = pc_addr;
               addr_next  = pc_addr;
               req_next   = 1'b1;
               tmo_next   = '0;
               state_next = FETCH_OP;
            end
         end
         FAULT: begin
            req_next = 1'b0;
            is_next  = '0;
         end
         default: begin
            req_next   = 1'b0;
            state_next = FETCH_OP;
         end
      endcase
   end

   // State and fetch datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= FETCH_OP;
         req_reg   <= 1'b0;
         addr_reg  <= '0;
         base_reg  <= '0;
         len_reg   <= '0;
         cnt_reg   <= '0;
         tmo_reg   <= '0;
         insn_reg  <= '0;
         is_reg    <= '0;
      end else begin
         state_reg <= state_next;
         req_reg   <= req_next;
         addr_reg  <= addr_next;
         base_reg  <= base_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         tmo_reg   <= tmo_next;
         insn_reg  <= insn_next;
         is_reg    <= is_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_opnd
         logic [7:0] d_byte_reg;
         // Operand byte gi+1: cleared when an operand fetch starts, loaded by its own ack.
         always_ff @(posedge clk) begin
            if (!rst) begin
               d_byte_reg <= '0;
            end else if (d_clr) begin
               d_byte_reg <= '0;
            end else if (d_wr && (cnt_reg == 2'(gi + 1))) begin
               d_byte_reg <= mem_rdata;
            end
         end
         assign d_bus[gi] = d_byte_reg;
      end
   endgenerate

   assign mem_req  = req_reg;
   assign mem_addr = addr_reg;
   assign insn     = insn_reg;
   assign d1       = d_bus[0];
   assign d2       = d_bus[1];
   assign d3       = d_bus[2];
   assign is       = is_reg;
   assign exec     = (state_reg == EXEC);
   assign halted   = (state_reg == HALT);
   assign fault    = (state_reg == FAULT);
endmodule

// File: tb/tb_iseq.sv
// tb_iseq: scoreboard bench for iseq. Expected fetch addresses and latched
// instruction bytes are queued when stimulus is set up, and popped on each
// memory ack and on each rising edge of exec.
module tb_iseq;
   typedef struct packed {
      logic [7:0] op;
      logic [7:0] b1;
      logic [7:0] b2;
      logic [7:0] b3;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc_addr = '0;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [1:0]  len = '0;
   logic        ins_end = 1'b0;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  insn, d1, d2, d3;
   logic [2:0]  is;
   logic        exec, halted, fault;

   logic [7:0]  mem [0:65535];
   logic [15:0] exp_addr [$];
   ins_t        exp_ins [$];
   int          n_total = 0;
   int          n_pass = 0;
   int          mem_wait = 0;
   int          end_step = -1;
   logic        mem_on = 1'b1;
   logic        late_ack = 1'b0;

   iseq #(.ADDR_W(16), .MAX_STEP(7), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .len(len), .ins_end(ins_end), .stall(stall),
      .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr), .insn(insn),
      .d1(d1), .d2(d2), .d3(d3), .is(is), .exec(exec), .halted(halted),
      .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      halt = 1'b0;
      stall = 1'b0;
      end_step = -1;
      tick(2);
      exp_addr.delete();
      exp_ins.delete();
   endtask

   task automatic wait_exec(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!exec && n < budget);
      check(tag, 64'(exec), 64'd1);
   endtask

   // Environment: memory responder, microcode end driver and insn monitor.
   initial begin
      int   wcnt;
      logic prev_exec;
      ins_t e;
      wcnt = 0;
      prev_exec = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && mem_on) begin
            if (wcnt >= mem_wait) begin
               mem_ack = 1'b1;
               mem_rdata = mem[mem_addr];
               wcnt = 0;
               check("fetch_expected", 64'(exp_addr.size() != 0), 64'd1);
               if (exp_addr.size() != 0)
                  check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end else begin
               mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ack = late_ack;
            wcnt = 0;
         end
         ins_end = exec && (int'(is) == end_step);
         if (exec && !prev_exec) begin
            check("insn_expected", 64'(exp_ins.size() != 0), 64'd1);
            if (exp_ins.size() != 0) begin
               e = exp_ins.pop_front();
               check("insn_d1_d2_d3", 64'({insn, d1, d2, d3}), 64'(e));
            end
         end
         prev_exec = exec;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      for (int a = 0; a < 65536; a++)
         mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;

      // Reset state
      do_reset();
      check("reset_outputs", 64'({mem_req, exec, halted, fault, is, insn, d1, d2, d3, mem_addr}), 64'd0);

      // 0-wait opcode, len=0, ins_end at is=2
      pc_addr = 16'h0100; mem[16'h0100] = 8'h3A; len = 2'd0; end_step = 2; mem_wait = 0;
      exp_addr.push_back(16'h0100);
      exp_ins.push_back('{8'h3A, 8'h00, 8'h00, 8'h00});
      rst = 1'b1;
      tick(1);
      check("t1_c1_req", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0100}));
      tick(1);
      check("t1_c2_decode", 64'({mem_req, exec, insn}), 64'({1'b0, 1'b0, 8'h3A}));
      tick(1);
      check("t1_c3_exec", 64'({exec, is}), 64'({1'b1, 3'd0}));
      pc_addr = 16'h0103;
      exp_addr.push_back(16'h0103);
      tick(1);
      check("t1_is1", 64'({exec, is}), 64'({1'b1, 3'd1}));
      tick(1);
      check("t1_is2", 64'({exec, is}), 64'({1'b1, 3'd2}));
      tick(1);
      check("t1_fetch_entry", 64'({exec, mem_req, is}), 64'd0);
      tick(1);
      check("t1_refetch", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0103}));

      // len=3 with 2 wait cycles per byte, then chained len=1 fetch wrapping at 0xFFFF
      do_reset();
      pc_addr = 16'h00FE; len = 2'd3; mem_wait = 2; end_step = 0;
      mem[16'h00FE] = 8'h47; mem[16'h00FF] = 8'h11; mem[16'h0100] = 8'h22; mem[16'h0101] = 8'h33;
      exp_addr.push_back(16'h00FE); exp_addr.push_back(16'h00FF);
      exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0101);
      exp_ins.push_back('{8'h47, 8'h11, 8'h22, 8'h33});
      rst = 1'b1;
      wait_exec("t2_reach_exec", 60);
      check("t2_operands", 64'({d1, d2, d3}), 64'(24'h112233));
      pc_addr = 16'hFFFF; len = 2'd1; mem_wait = 0;
      mem[16'hFFFF] = 8'h5C; mem[16'h0000] = 8'h77;
      exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000);
      exp_ins.push_back('{8'h5C, 8'h77, 8'h00, 8'h00});
      wait_exec("t2_wrap_exec", 30);
      check("t2_wrap_d1", 64'(d1), 64'(8'h77));

      // Stall holds the step even with ins_end high
      do_reset();
      pc_addr = 16'h0200; mem[16'h0200] = 8'h9C; len = 2'd0; end_step = 1;
      exp_addr.push_back(16'h0200);
      exp_ins.push_back('{8'h9C, 8'h00, 8'h00, 8'h00});
      rst = 1'b1;
      wait_exec("t3_reach_exec", 20);
      tick(1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check("t3_stall_hold", 64'({exec, is}), 64'({1'b1, 3'd1}));
      end
      stall = 1'b0;
      tick(1);
      check("t3_stall_exit", 64'({exec, is, mem_req}), 64'd0);

      // Step overrun: ins_end never arrives
      do_reset();
      pc_addr = 16'h0300; len = 2'd0;
      exp_addr.push_back(16'h0300);
      exp_ins.push_back('{mem[16'h0300], 8'h00, 8'h00, 8'h00});
      rst = 1'b1;
      wait_exec("t4_reach_exec", 20);
      tick(7);
      check("t4_is7", 64'({exec, is}), 64'({1'b1, 3'd7}));
      tick(1);
      check("t4_overrun", 64'({fault, exec, mem_req, is}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
      tick(4);
      check("t4_sticky", 64'({fault, exec, mem_req}), 64'({1'b1, 1'b0, 1'b0}));
      do_reset();
      check("t4_fault_clear", 64'({fault, halted, exec, mem_req}), 64'd0);

      // Memory timeout, then a late ack is ignored
      mem_on = 1'b0;
      pc_addr = 16'h0400;
      rst = 1'b1;
      tick(1);
      check("t5_req", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h0400}));
      tick(14);
      check("t5_before_timeout", 64'({mem_req, fault}), 64'({1'b1, 1'b0}));
      tick(1);
      check("t5_timeout", 64'({mem_req, fault}), 64'({1'b0, 1'b1}));
      late_ack = 1'b1;
      tick(3);
      check("t5_late_ack", 64'({fault, mem_req, exec, insn}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
      late_ack = 1'b0;
      mem_on = 1'b1;

      // Halt mid-EXEC, release, then reset during operand fetch
      do_reset();
      pc_addr = 16'h0500; mem[16'h0500] = 8'hC1; len = 2'd0; end_step = 2;
      exp_addr.push_back(16'h0500);
      exp_ins.push_back('{8'hC1, 8'h00, 8'h00, 8'h00});
      rst = 1'b1;
      wait_exec("t6_reach_exec", 20);
      halt = 1'b1;
      tick(2);
      check("t6_completes", 64'({exec, is}), 64'({1'b1, 3'd2}));
      tick(1);
      check("t6_entry", 64'({exec, mem_req, halted}), 64'd0);
      tick(1);
      check("t6_halted", 64'({halted, mem_req}), 64'({1'b1, 1'b0}));
      tick(3);
      check("t6_halt_hold", 64'({halted, mem_req, exec}), 64'({1'b1, 1'b0, 1'b0}));
      pc_addr = 16'h0600; len = 2'd3; mem_wait = 1;
      exp_addr.push_back(16'h0600); exp_addr.push_back(16'h0601); exp_addr.push_back(16'h0602);
      halt = 1'b0;
      tick(1);
      check("t6_resume", 64'({mem_req, halted, mem_addr}), 64'({1'b1, 1'b0, 16'h0600}));
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick(1);
         if (mem_req && mem_addr == 16'h0602) found = 1'b1;
      end
      check("t6_in_fetch_d", 64'(found), 64'd1);
      rst = 1'b0;
      tick(1);
      check("t6_reset_outputs", 64'({mem_req, exec, halted, fault, is, insn, d1, d2, d3, mem_addr}), 64'd0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/iseq.md
Name: iseq

Overview:
Instruction fetch/step sequencer for the 8-bit core. It fetches the opcode byte and 0-3 operand bytes from memory through a req/ack handshake, and presents insn, d1, d2 and d3 to the microcode decoder block. It then generates the microcode step index `is` until the microcode signals end-of-instruction. It owns the fetch → decode → execute loop, halt handling and fault detection, including step overrun and memory timeout.

Parameters:
ADDR_W, 16, memory/PC address width
MAX_STEP, 7, last legal microcode step index (ucode steps per opcode minus 1)
MEM_TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before FAULT

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
pc_addr  in  ADDR_W  current program counter from PC unit
mem_rdata  in  8  read data, valid when mem_ack=1
mem_ack  in  1  read acknowledge
len  in  2  operand byte count for latched insn, from decoder
ins_end  in  1  microcode end-of-instruction (pc_ini|pc_lrc of current step)
stall  in  1  hold current step
halt  in  1  halt request, honoured at instruction boundary
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address
insn  out  8  latched opcode
d1, d2, d3  out  8 each  latched operand bytes 1..3
is  out  3  microcode step index
exec  out  1  high in EXEC; datapath gates ucode strobes with it
halted  out  1  high in HALT
fault  out  1  sticky fault flag

Behaviour:
- Reset (rst=0 at posedge):
  - state=FETCH_OP, all outputs 0, base=0, byte count=0, timeout count=0.
  - Applies from any state; an in-flight request is abandoned.
- States: FETCH_OP, FETCH_D, DECODE, EXEC, HALT, FAULT.
- FETCH_OP:
  - On entry cycle, if halt=1, go to HALT with no request.
  - Otherwise latch base=pc_addr, assert mem_req with mem_addr=base.
  - On posedge with mem_req&mem_ack: insn<=mem_rdata, go to DECODE.
- DECODE: exactly one cycle with mem_req=0. At its posedge len is sampled:
  - len=0 → EXEC.
  - Otherwise clear d1..d3 to 0 and go to FETCH_D.
- FETCH_D:
  - Byte k=1..len fetched from mem_addr=base+k (ADDR_W-bit, wraps modulo 2^ADDR_W).
  - Each ack writes d<k>.
  - mem_req stays high between consecutive bytes; mem_addr advances the cycle after each ack.
  - After byte len is acked → EXEC.
  - Unused dN remain 0.
- Handshake:
  - mem_addr is stable while mem_req=1 and no ack.
  - mem_ack is ignored when mem_req=0.
  - Ack may arrive on the first request cycle (zero wait).
- Timeout:
  - The counter resets on each ack and on request start, and counts cycles with mem_req=1 & mem_ack=0.
  - When it reaches MEM_TIMEOUT → FAULT, mem_req drops next cycle.
- EXEC:
  - exec=1, is starts at 0. Per posedge, evaluated in this order:
    - stall=1: hold is, ignore ins_end.
    - ins_end=1: is<=0, exec<=0, go to FETCH_OP.
    - is==MAX_STEP: go to FAULT (step overrun).
    - Otherwise is<=is+1.
  - halt during EXEC has no effect until the instruction ends.
- HALT: halted=1, mem_req=0. Stays while halt=1; halt=0 → FETCH_OP.
- FAULT: fault=1, exec=0, mem_req=0, is=0. Sticky until reset; insn and d1..d3 are retained for debug.
- insn and d1..d3 hold their values from the end of fetch until the next FETCH_OP ack.
- Latency: a 0-wait memory with len=2 gives opcode req → EXEC in 4 cycles (FETCH_OP, DECODE, 2×FETCH_D).

Test Plan:
- Reset release, pc_addr=0x0100, mem returns 0x3A with 0-wait, len=0, ins_end at is=2:
  - mem_addr=0x0100 at cycle 1, DECODE at cycle 2, exec at cycle 3.
  - is goes 0,1,2, then FETCH_OP with mem_req=1.
- pc_addr=0x00FE, len=3, memory bytes 0x11,0x22,0x33 with 2 wait cycles each:
  - addresses 0x00FF, 0x0100, 0x0101 issued.
  - d1=0x11, d2=0x22, d3=0x33.
  - Wrap at pc_addr=0xFFFF gives d1 fetched from 0x0000.
- EXEC with stall=1 for 3 cycles at is=1 while ins_end=1:
  - is stays 1 and exec stays 1.
  - After stall drops, exit to FETCH_OP on the next edge.
- EXEC with ins_end never asserted: is reaches 7, then next edge fault=1, exec=0, mem_req=0; fault persists until rst=0.
- mem_ack withheld for 15 cycles: fault=1 on the edge the count hits 15. A late ack afterwards is ignored.
- halt=1 asserted mid-EXEC: the instruction completes, then HALT with halted=1 and no request. halt=0 gives mem_req=1 the next cycle. rst=0 mid-FETCH_D returns all outputs to 0.
